// File: rtl/oam_dma_arbiter.sv
// ============================================================================
// Module   : oam_dma_arbiter
// Purpose  : OAM DMA engine (0xFF46) plus CPU/DMA arbitration of the ext bus.
//            Optional macro DMA_CPU_PRIORITY_EN: CPU ext accesses stall the DMA.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module oam_dma_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_rd_en,
  input  logic        cpu_wr_en,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        ext_rd_en,
  output logic        ext_wr_en,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  input  logic [7:0]  ext_rdata,
  output logic        hi_rd_en,
  output logic        hi_wr_en,
  output logic [15:0] hi_addr,
  output logic [7:0]  hi_wdata,
  input  logic [7:0]  hi_rdata,
  output logic        oam_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        dma_active
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_XFER  = 2'd2
  } state_t;

  localparam logic [15:0] C_DMA_REG_ADDR = 16'hFF46;
  localparam logic [7:0]  C_LAST_IDX     = 8'd159;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_idx;
  logic [7:0]  w_idx_nxt;
  logic [7:0]  r_dma_reg;
  logic [7:0]  w_src;
  logic        w_cpu_wr;
  logic        w_cpu_rd;
  logic        w_cpu_req;
  logic        w_is_dma_reg;
  logic        w_is_hi;
  logic        w_is_ext;
  logic        w_dma_trig;
  logic        w_cpu_win;
  logic        w_dma_xfer;
  logic        w_cpu_ext_ok;

  // A simultaneous read and write is handled as a write.
  assign w_cpu_wr     = cpu_wr_en;
  assign w_cpu_rd     = cpu_rd_en & ~cpu_wr_en;
  assign w_cpu_req    = cpu_rd_en | cpu_wr_en;
  assign w_is_dma_reg = (cpu_addr == C_DMA_REG_ADDR);
  assign w_is_hi      = (cpu_addr[15:8] == 8'hFF) & ~w_is_dma_reg;
  assign w_is_ext     = (cpu_addr[15:8] != 8'hFF);
  assign w_dma_trig   = w_cpu_wr & w_is_dma_reg;

  // Echo RAM fold: 0xE0-0xFF source pages mirror 0xC0-0xDF.
  assign w_src = (r_dma_reg >= 8'hE0) ? (r_dma_reg - 8'h20) : r_dma_reg;

`ifdef DMA_CPU_PRIORITY_EN
  assign w_cpu_win = (r_state == ST_XFER) & w_cpu_req & w_is_ext;
`else
  assign w_cpu_win = 1'b0;
`endif

  assign w_dma_xfer   = (r_state == ST_XFER) & ~w_cpu_win;
  assign w_cpu_ext_ok = w_cpu_req & w_is_ext & ((r_state != ST_XFER) | w_cpu_win);
  assign dma_active   = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= 8'd0;
      r_dma_reg <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_dma_trig) begin
        r_dma_reg <= cpu_wdata;
      end
    end
  end

  // A write to the DMA register restarts the engine from any state.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (w_dma_trig) begin
      w_state_nxt = ST_START;
      w_idx_nxt   = 8'd0;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_IDLE;
        ST_START: w_state_nxt = ST_XFER;
        ST_XFER: begin
          if (w_dma_xfer) begin
            if (r_idx == C_LAST_IDX) begin
              w_state_nxt = ST_IDLE;
              w_idx_nxt   = 8'd0;
            end else begin
              w_idx_nxt = r_idx + 8'd1;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    ext_rd_en = 1'b0;
    ext_wr_en = 1'b0;
    ext_addr  = 16'h0000;
    ext_wdata = 8'h00;
    hi_rd_en  = 1'b0;
    hi_wr_en  = 1'b0;
    hi_addr   = 16'h0000;
    hi_wdata  = 8'h00;
    oam_we    = 1'b0;
    oam_addr  = 8'h00;
    oam_wdata = 8'h00;
    cpu_rdata = 8'h00;

    if (w_dma_xfer) begin
      ext_rd_en = 1'b1;
      ext_addr  = {w_src, r_idx};
      oam_we    = 1'b1;
      oam_addr  = r_idx;
      oam_wdata = ext_rdata;
    end else if (w_cpu_ext_ok) begin
      ext_rd_en = w_cpu_rd;
      ext_wr_en = w_cpu_wr;
      ext_addr  = cpu_addr;
      ext_wdata = w_cpu_wr ? cpu_wdata : 8'h00;
    end

    if (w_cpu_req & w_is_hi) begin
      hi_rd_en = w_cpu_rd;
      hi_wr_en = w_cpu_wr;
      hi_addr  = cpu_addr;
      hi_wdata = w_cpu_wr ? cpu_wdata : 8'h00;
    end

    // A CPU read blocked by the DMA floats high, as on an undriven bus.
    if (w_cpu_rd) begin
      if (w_is_dma_reg) begin
        cpu_rdata = r_dma_reg;
      end else if (w_is_hi) begin
        cpu_rdata = hi_rdata;
      end else if (w_cpu_ext_ok) begin
        cpu_rdata = ext_rdata;
      end else begin
        cpu_rdata = 8'hFF;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/oam_dma_arbiter.md
OAM_DMA_ARBITER -- requirements
Module: oam_dma_arbiter

Interface
REQ-001 SHALL have ports clk (input, 1, sole clock; all state on posedge) and rst_n (input, 1, asynchronous, active-low reset).
REQ-002 SHALL have inputs cpu_rd_en (1), cpu_wr_en (1), cpu_addr (16) and cpu_wdata (8), plus output cpu_rdata (8): the CPU bus request and its combinational read return.
REQ-003 SHALL have outputs ext_rd_en (1), ext_wr_en (1), ext_addr (16) and ext_wdata (8), plus input ext_rdata (8): the shared bus for 0x0000-0xFEFF, with combinational read.
REQ-004 SHALL have outputs hi_rd_en (1), hi_wr_en (1), hi_addr (16) and hi_wdata (8), plus input hi_rdata (8): the bus for 0xFF00-0xFFFF, excluding 0xFF46.
REQ-005 SHALL have outputs oam_we (1), oam_addr (8) and oam_wdata (8): the OAM write port, driven by DMA only.
REQ-006 SHALL have output dma_active (1): high while state is not IDLE.

Function
REQ-007 SHALL hold an 8-bit DMA register at 0xFF46; a CPU write loads it; a CPU read returns it combinationally; neither access is forwarded to hi.
REQ-008 SHALL implement FSM IDLE -> START -> XFER -> IDLE, with 8-bit byte counter idx (0..159).
REQ-009 A CPU write to 0xFF46 sampled at an edge SHALL, at that edge, load the register, set state to START and clear idx; this applies in any state (restart).
REQ-010 START SHALL last exactly one cycle with no transfer, then go to XFER.
REQ-011 In each XFER cycle where DMA owns ext, ext_rd_en=1 and ext_addr={src,idx}; oam_we=1, oam_addr=idx, oam_wdata=ext_rdata (same cycle); idx increments at the edge.
REQ-012 src SHALL be the register value minus 0x20 when the register is 0xE0-0xFF (echo fold), otherwise the register value unchanged.
REQ-013 The XFER cycle with idx=159 that transfers SHALL be the last; the next state is IDLE and idx returns to 0.
REQ-014 Without stalls, dma_active SHALL be high for exactly 161 cycles after the triggering edge.
REQ-015 CPU accesses to 0xFF00-0xFFFF other than 0xFF46 SHALL always pass through to hi (rd/wr/addr/wdata), with cpu_rdata=hi_rdata, in any state.
REQ-016 In IDLE and START, CPU accesses to 0x0000-0xFEFF SHALL pass through to ext, with cpu_rdata=ext_rdata.
REQ-017 In XFER, CPU ext-range accesses are arbitrated per REQ-022/023; a blocked CPU read SHALL return 0xFF and a blocked CPU write SHALL not reach ext.
REQ-018 With no request, all bus enables SHALL be 0 and addr/wdata outputs 0; oam_we SHALL be 0 outside XFER transfer cycles.
REQ-019 Simultaneous CPU rd_en and wr_en SHALL be treated as a write.

Reset
REQ-020 On rst_n low, the block SHALL asynchronously set state to IDLE, idx to 0, the DMA register to 0x00 and dma_active to 0.
REQ-021 Reset asserted mid-XFER SHALL abort the transfer; no further oam_we pulses occur until a new 0xFF46 write.

Configuration
REQ-022 With macro DMA_CPU_PRIORITY_EN defined, a CPU ext-range access during XFER SHALL win: it is forwarded to ext, that cycle oam_we=0 and idx holds (the DMA stalls one cycle).
REQ-023 With DMA_CPU_PRIORITY_EN undefined, DMA SHALL always own ext during XFER and CPU ext-range accesses are blocked per REQ-017.

Verification
REQ-024 Write 0xC1 to 0xFF46, ext memory 0xC100+i=i^0x5A -> 160 oam_we pulses starting 2 cycles after the write, OAM[i]=i^0x5A, dma_active high for 161 cycles.
REQ-025 Write 0xF0 -> ext_addr sequence 0xD000..0xD09F (echo fold).
REQ-026 Rewrite 0x80 at idx=50 -> one START cycle, then restart at 0x8000 with idx=0; 160 further pulses.
REQ-027 CPU reads 0xFF85 and 0xC000 during XFER -> hi_rdata returned; 0xC000 read returns 0xFF (macro undefined), or ext_rdata plus a one-cycle DMA stall and 161 total XFER cycles (macro defined).
REQ-028 rst_n low at idx=80 -> immediate IDLE, dma_active=0, register 0x00, no oam_we afterwards.
REQ-029 Read 0xFF46 after writing 0xA5 -> cpu_rdata=0xA5, hi_rd_en=0.
